// File: rtl/fc_argmax_unit.sv
// fc_argmax_unit: fully connected classifier head with argmax output.
// Collects NUM_IN pooled features, runs one MAC per cycle, emits best class.
module fc_argmax_unit #(
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 10,
    parameter int ACC_W   = 20,
    localparam int NW     = NUM_IN * NUM_OUT,
    localparam int AW     = (NW > 1) ? $clog2(NW) : 1,
    localparam int IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int CW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    w_wr_en,
    input  logic [AW-1:0]           w_addr,
    input  logic [7:0]              w_data,
    output logic                    out_valid,
    output logic [CW-1:0]           out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    overrun
);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_MAC     = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [IW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           i_q, i_d;
    logic [CW-1:0]           o_q, o_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic [CW-1:0]           best_cls_q, best_cls_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic [CW-1:0]           cls_q, cls_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    logic [7:0]              feat_q [NUM_IN];
    logic signed [7:0]       w_q [NW];

    logic                    collecting;
    logic                    capture;
    logic                    last_feat;
    logic [AW-1:0]           widx;
    logic [7:0]              feat_sel;
    logic signed [7:0]       w_sel;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] sum;
    logic                    last_i;
    logic                    last_o;
    logic                    take;

    assign collecting = (state_q == S_COLLECT);
    assign capture    = collecting && in_valid;
    assign last_feat  = (cnt_q == IW'(NUM_IN - 1));
    assign in_ready   = collecting;

    assign out_valid  = valid_q;
    assign out_class  = cls_q;
    assign out_score  = score_q;
    assign overrun    = ovr_q;

    // MAC datapath: feature is zero-extended so it multiplies as a positive value
    always_comb begin
        widx     = AW'(int'(o_q) * NUM_IN + int'(i_q));
        feat_sel = feat_q[i_q];
        w_sel    = w_q[widx];
        prod     = $signed({1'b0, feat_sel}) * w_sel;
        sum      = acc_q + ACC_W'(prod);
        last_i   = (i_q == IW'(NUM_IN - 1));
        last_o   = (o_q == CW'(NUM_OUT - 1));
        take     = (o_q == '0) || (sum > best_q);
    end

    // Control and argmax next-state; strict compare keeps the lower index on ties
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        o_d        = o_q;
        acc_d      = acc_q;
        best_d     = best_q;
        best_cls_d = best_cls_q;
        score_d    = score_q;
        cls_d      = cls_q;
        valid_d    = 1'b0;
        ovr_d      = ovr_q | (in_valid && !collecting);

        unique case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    if (last_feat) begin
                        cnt_d   = '0;
                        state_d = S_MAC;
                        i_d     = '0;
                        o_d     = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (last_i) begin
                    acc_d = '0;
                    i_d   = '0;
                    if (take) begin
                        best_d     = sum;
                        best_cls_d = o_q;
                    end
                    if (last_o) begin
                        state_d = S_COLLECT;
                        o_d     = '0;
                        valid_d = 1'b1;
                        score_d = take ? sum : best_q;
                        cls_d   = take ? o_q : best_cls_q;
                    end else begin
                        o_d = o_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    i_d   = i_q + 1'b1;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Control, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_COLLECT;
            cnt_q      <= '0;
            i_q        <= '0;
            o_q        <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            best_cls_q <= '0;
            score_q    <= '0;
            cls_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            o_q        <= o_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_cls_q <= best_cls_d;
            score_q    <= score_d;
            cls_q      <= cls_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    // Feature buffer, filled in arrival order while collecting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_IN; k++) begin
                feat_q[k] <= '0;
            end
        end else if (capture) begin
            feat_q[cnt_q] <= in_data;
        end
    end

    // Weight memory; writes are frozen while the MAC is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (collecting && w_wr_en && (int'(w_addr) < NW)) begin
            w_q[w_addr] <= $signed(w_data);
        end
    end

endmodule

// File: tb/tb_fc_argmax_unit.sv
// Testbench for fc_argmax_unit: table of weight/feature vectors plus
// hand sequences for overrun, back-to-back frames, reset and frozen writes.
module tb_fc_argmax_unit;

    localparam int NI  = 8;
    localparam int NO  = 10;
    localparam int AW  = 7;
    localparam int CW  = 4;
    localparam int ACW = 20;
    localparam int LAT = NI * NO;

    localparam int P_DIAG = 0;
    localparam int P_ZERO = 1;
    localparam int P_NEG  = 2;
    localparam int P_M128 = 3;
    localparam int P_TIE  = 4;
    localparam int P_LAST = 5;
    localparam int P_RAND = 6;

    logic                  clk;
    logic                  rst_n;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  w_wr_en;
    logic [AW-1:0]         w_addr;
    logic [7:0]            w_data;
    logic                  out_valid;
    logic [CW-1:0]         out_class;
    logic signed [ACW-1:0] out_score;
    logic                  overrun;

    fc_argmax_unit #(.NUM_IN(NI), .NUM_OUT(NO), .ACC_W(ACW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_wr_en  (w_wr_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .out_valid(out_valid),
        .out_class(out_class),
        .out_score(out_score),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cls;
        int score;
        int cap;
    } exp_t;

    typedef struct {
        int               pat;
        logic [7:0][7:0]  f;
        int               cls;
        int               score;
        bit               use_model;
    } vec_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;
    logic prev_ov = 1'b0;
    logic signed [7:0] tw [NI*NO];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [7:0] wgt(input int pat, input int o, input int i);
        logic signed [7:0] r;
        r = 8'sd0;
        case (pat)
            P_DIAG: r = (i == o % 8) ? 8'sd1 : 8'sd0;
            P_NEG:  r = (o < 9) ? -8'sd1 : -8'sd2;
            P_M128: r = -8'sd128;
            P_TIE:  r = (o == 3 || o == 5) ? 8'sd1 : 8'sd0;
            P_LAST: r = (o == 9) ? 8'sd2 : 8'sd1;
            P_RAND: r = tw[o*NI+i];
            default: r = 8'sd0;
        endcase
        return r;
    endfunction

    function automatic void model(input int pat, input logic [7:0][7:0] f,
                                  output int cls, output int sc);
        int s;
        cls = 0;
        sc  = 0;
        for (int o = 0; o < NO; o++) begin
            s = 0;
            for (int i = 0; i < NI; i++) begin
                s += int'(f[i]) * int'(wgt(pat, o, i));
            end
            if (o == 0 || s > sc) begin
                sc  = s;
                cls = o;
            end
        end
    endfunction

    function automatic logic [7:0][7:0] mk_f(input int start, input int step);
        logic [7:0][7:0] f;
        for (int k = 0; k < NI; k++) begin
            f[k] = 8'(start + step * k);
        end
        return f;
    endfunction

    // Scoreboard: every result is popped and compared here
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got class %0d score %0d, expected none",
                         out_class, out_score);
            end else begin
                e = sbq.pop_front();
                chk("out_class", int'(out_class), e.cls);
                chk("out_score", out_score, e.score);
                chk("latency", cyc - e.cap, LAT);
            end
            if (prev_ov) begin
                tests++;
                fails++;
                $display("FAIL out_valid_width: got 2+ cycles, expected 1");
            end
        end
        prev_ov = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int pat);
        for (int idx = 0; idx < NI*NO; idx++) begin
            w_wr_en = 1'b1;
            w_addr  = AW'(idx);
            w_data  = wgt(pat, idx / NI, idx % NI);
            tick();
        end
        w_wr_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0][7:0] f, input int gap,
                              input bit push, input int cls, input int sc);
        bit rdy_ok;
        exp_t e;
        rdy_ok = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if (!in_ready) rdy_ok = 1'b0;
            in_data  = f[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (k != NI - 1) repeat (gap) tick();
        end
        chk("in_ready_collect", rdy_ok, 1);
        if (push) begin
            e.cls   = cls;
            e.score = sc;
            e.cap   = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("in_ready_low_in_mac", busy_ok, 1);
        chk("in_ready_at_result", in_ready, 1);
    endtask

    vec_t vecs[7];
    logic [7:0][7:0] fr;
    int ecls, esc;

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        w_wr_en  = 1'b0;
        w_addr   = '0;
        w_data   = '0;

        vecs[0] = '{P_DIAG, mk_f(10, 10),  7, 80,      1'b0};
        vecs[1] = '{P_NEG,  mk_f(255, 0),  0, -2040,   1'b0};
        vecs[2] = '{P_M128, mk_f(255, 0),  0, -261120, 1'b0};
        vecs[3] = '{P_TIE,  mk_f(100, 0),  3, 800,     1'b0};
        vecs[4] = '{P_LAST, mk_f(1, 1),    9, 72,      1'b0};
        vecs[5] = '{P_DIAG, mk_f(80, -10), 0, 80,      1'b0};
        vecs[6] = '{P_RAND, mk_f(0, 0),    0, 0,       1'b1};

        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_score", out_score, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Reset weights are all zero: every class ties at 0
        send_frame(mk_f(10, 10), 0, 1'b1, 0, 0);
        wait_done();

        for (int v = 0; v < 7; v++) begin
            fr   = vecs[v].f;
            ecls = vecs[v].cls;
            esc  = vecs[v].score;
            if (vecs[v].use_model) begin
                for (int k = 0; k < NI*NO; k++) tw[k] = 8'($urandom_range(0, 255));
                for (int k = 0; k < NI; k++) fr[k] = 8'($urandom_range(0, 255));
                model(P_RAND, fr, ecls, esc);
            end
            load_w(vecs[v].pat);
            send_frame(fr, 0, 1'b1, ecls, esc);
            wait_done();
        end

        // Stray feature during MAC: dropped, sticky overrun
        load_w(P_DIAG);
        send_frame(mk_f(10, 10), 0, 1'b1, 7, 80);
        repeat (4) tick();
        in_data  = 8'd99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done();
        chk("overrun_set", overrun, 1);
        send_frame(mk_f(10, 10), 0, 1'b1, 7, 80);
        wait_done();
        chk("overrun_sticky", overrun, 1);

        // Sparse frame then a frame starting right after out_valid
        send_frame(mk_f(10, 10), 195, 1'b1, 7, 80);
        wait_done();
        send_frame(mk_f(80, -10), 0, 1'b1, 0, 80);
        wait_done();

        // Reset in the middle of MAC
        send_frame(mk_f(10, 10), 0, 1'b0, 0, 0);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_class", int'(out_class), 0);
        chk("midrst_out_score", out_score, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        send_frame(mk_f(10, 10), 0, 1'b1, 0, 0);
        wait_done();
        load_w(P_DIAG);
        send_frame(mk_f(10, 10), 0, 1'b1, 7, 80);
        wait_done();

        // Weight write during MAC must be ignored
        send_frame(mk_f(10, 10), 0, 1'b1, 7, 80);
        repeat (3) tick();
        w_wr_en = 1'b1;
        w_addr  = AW'(7*NI + 7);
        w_data  = 8'(-100);
        tick();
        w_wr_en = 1'b0;
        wait_done();
        send_frame(mk_f(10, 10), 0, 1'b1, 7, 80);
        wait_done();

        repeat (3) tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
